freq_meter_hyst: RTL
====================

FREQ_METER_HYST -- requirements
Module: freq_meter_hyst

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 12, meaning signed input sample width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning period counter and output width.
REQ-003 SHALL have parameter AVG_LOG2, default 2, meaning averaging depth of 2**AVG_LOG2 periods.
REQ-004 SHALL have parameter HYST, default 8, meaning hysteresis threshold in LSBs (>=0).
REQ-005 SHALL have parameter TOL, default 1, meaning stability tolerance in counts.
REQ-006 SHALL have parameter STABLE_CYCLES, default 3, meaning consecutive in-tolerance periods needed for stable.
REQ-007 SHALL have port adc_clk, input, 1, sampling clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-009 SHALL have port clear, input, 1, synchronous restart of measurement.
REQ-010 SHALL have port data_valid, input, 1, data_in qualifier.
REQ-011 SHALL have port data_in, input, DATA_WIDTH signed, DC-free sample.
REQ-012 SHALL have port period, output, CNT_WIDTH, averaged period in samples.
REQ-013 SHALL have port period_valid, output, 1, one-cycle pulse when period updates.
REQ-014 SHALL have port stable, output, 1, frequency-stable flag.
REQ-015 SHALL have port no_signal, output, 1, timeout flag.

Function
REQ-016 SHALL keep polarity state: NEG->POS when data_in >= +HYST, POS->NEG when data_in <= -HYST, evaluated only when data_valid=1.
REQ-017 SHALL define a rising event as a NEG->POS transition; only rising events delimit periods.
REQ-018 SHALL count data_valid samples since the last rising event; the measured period is the count at the event, including the event sample.
REQ-019 SHALL use FSM states ACQ (no reference edge yet), TRACK (counting), and TIMEOUT.
REQ-020 SHALL move ACQ->TRACK on the first rising event, discarding that count.
REQ-021 SHALL, in TRACK, push each measured period into a 2**AVG_LOG2-entry ring buffer and maintain a running sum of CNT_WIDTH+AVG_LOG2 bits.
REQ-022 SHALL suppress period_valid until the buffer is full; afterwards, the cycle after each push, it SHALL output period = sum >> AVG_LOG2 (truncating) and pulse period_valid.
REQ-023 SHALL move to TIMEOUT when the counter reaches 2**CNT_WIDTH-1, saturating the counter, setting no_signal=1, clearing stable, and flushing the buffer.
REQ-024 SHALL move TIMEOUT->TRACK on the next rising event, clearing no_signal and restarting the count without recording a period.
REQ-025 SHALL, on each push with a full buffer, compare the new period with the current period output: if |diff| <= TOL, increment the stable counter (saturating at STABLE_CYCLES); otherwise reset it to 0.
REQ-026 SHALL assert stable exactly when the stable counter equals STABLE_CYCLES.
REQ-027 SHALL, on clear=1, return to ACQ, flush the buffer, zero the counter and sum, and deassert stable, period_valid, and no_signal; period holds its value; clear overrides a simultaneous event.
REQ-028 SHALL, when data_valid=0, hold the counter, polarity, and FSM state.

Reset
REQ-029 SHALL reset asynchronously on rst_n low: period=0, period_valid=0, stable=0, no_signal=0, FSM=ACQ, polarity=NEG, counter, sum, and buffer at 0.
REQ-030 SHALL release reset synchronously to adc_clk; the first sample is evaluated on the first edge after release.

Structure
REQ-031 SHALL place the FSM state enum and default parameter constants in the shared package freq_meter_pkg.
REQ-032 SHALL implement the hysteresis comparator as sub-module zc_hyst_cmp, which outputs the polarity and a rise pulse.

Verification
REQ-033 SHALL cover a square wave of +-100 with period 50 and data_valid=1: the first period_valid comes after 1+4 rising events, period=50, and stable=1 after 3 further periods.
REQ-034 SHALL cover a sine with amplitude 100 plus +-6 noise and HYST=8: no spurious events, period within +-1 of true.
REQ-035 SHALL cover a step in period from 50 to 80: the stable counter drops to 0 and stable=0 on the first 80-count push; period ramps through the averages; stable returns after STABLE_CYCLES in-tolerance pushes.
REQ-036 SHALL cover a constant-zero input with CNT_WIDTH=8: no_signal=1 after 255 samples past the last event, stable=0, and recovery on the next rising event.
REQ-037 SHALL cover data_valid toggling every other cycle on a period-50-sample wave: period=50 in samples, not cycles.
REQ-038 SHALL cover clear or rst_n asserted mid-TRACK: outputs take their cleared/reset values; re-acquisition requires a new first edge plus a full buffer.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and default parameters for the hysteresis zero-crossing frequency meter.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    ST_ACQ     = 2'd0,
    ST_TRACK   = 2'd1,
    ST_TIMEOUT = 2'd2
  } fm_state_e;

  localparam int DEF_DATA_WIDTH    = 12;
  localparam int DEF_CNT_WIDTH     = 16;
  localparam int DEF_AVG_LOG2      = 2;
  localparam int DEF_HYST          = 8;
  localparam int DEF_TOL           = 1;
  localparam int DEF_STABLE_CYCLES = 3;

endpackage

// File: rtl/zc_hyst_cmp.sv
// Schmitt-style polarity tracker: outputs the current polarity and a one-cycle
// combinational pulse on the sample that flips it from NEG to POS.
module zc_hyst_cmp
  import freq_meter_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int HYST       = DEF_HYST
) (
  input  logic                         adc_clk,
  input  logic                         rst_n,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_pol,
  output logic                         o_rise
);

  localparam logic signed [DATA_WIDTH-1:0] c_hi = DATA_WIDTH'(HYST);
  localparam logic signed [DATA_WIDTH-1:0] c_lo = DATA_WIDTH'(-HYST);

  logic r_pol;
  logic w_rise;
  logic w_fall;

  assign w_rise = i_valid && !r_pol && (i_data >= c_hi);
  assign w_fall = i_valid &&  r_pol && (i_data <= c_lo);

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n)      r_pol <= 1'b0;
    else if (w_rise) r_pol <= 1'b1;
    else if (w_fall) r_pol <= 1'b0;
  end

  assign o_pol  = r_pol;
  assign o_rise = w_rise;

endmodule

// File: rtl/freq_meter_hyst.sv
// Period meter: counts valid samples between rising hysteresis crossings, averages
// the last 2**AVG_LOG2 periods, and flags stability and loss of signal.
module freq_meter_hyst
  import freq_meter_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int AVG_LOG2      = DEF_AVG_LOG2,
  parameter int HYST          = DEF_HYST,
  parameter int TOL           = DEF_TOL,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
  input  logic                         adc_clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         data_valid,
  input  logic signed [DATA_WIDTH-1:0] data_in,
  output logic        [CNT_WIDTH-1:0]  period,
  output logic                         period_valid,
  output logic                         stable,
  output logic                         no_signal
);

  localparam int N      = 2 ** AVG_LOG2;
  localparam int SUM_W  = CNT_WIDTH + AVG_LOG2;
  localparam int PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int STAB_W = ($clog2(STABLE_CYCLES + 1) > 0) ? $clog2(STABLE_CYCLES + 1) : 1;

  localparam logic [CNT_WIDTH-1:0] c_cnt_max  = '1;
  localparam logic [AVG_LOG2:0]    c_full     = (AVG_LOG2 + 1)'(N);
  localparam logic [STAB_W-1:0]    c_stab_max = STAB_W'(STABLE_CYCLES);
  localparam logic [CNT_WIDTH:0]   c_tol      = (CNT_WIDTH + 1)'(TOL);

  fm_state_e r_state, w_state_next;

  logic                        w_rise;
  logic                        w_pol_unused;  // polarity kept visible for debug only
  logic [CNT_WIDTH-1:0]        r_cnt;
  logic [CNT_WIDTH-1:0]        w_cnt_inc;
  logic [CNT_WIDTH-1:0]        r_buf [N];
  logic [PTR_W-1:0]            r_wr_ptr;
  logic [AVG_LOG2:0]           r_fill, w_fill_next;
  logic [SUM_W-1:0]            r_sum, w_sum_next;
  logic [CNT_WIDTH-1:0]        w_old;
  logic [STAB_W-1:0]           r_stab;
  logic signed [CNT_WIDTH:0]   w_diff;
  logic [CNT_WIDTH:0]          w_abs;
  logic                        w_in_tol;
  logic                        w_full;
  logic                        w_push;
  logic                        w_to_timeout;
  logic                        w_recover;
  logic                        w_flush;

  zc_hyst_cmp #(
    .DATA_WIDTH (DATA_WIDTH),
    .HYST       (HYST)
  ) u_cmp (
    .adc_clk (adc_clk),
    .rst_n   (rst_n),
    .i_valid (data_valid),
    .i_data  (data_in),
    .o_pol   (w_pol_unused),
    .o_rise  (w_rise)
  );

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_ACQ;
    else        r_state <= w_state_next;
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    w_push       = 1'b0;
    w_to_timeout = 1'b0;
    w_recover    = 1'b0;
    if (clear) begin
      w_state_next = ST_ACQ;
    end else if (data_valid) begin
      unique case (r_state)
        ST_ACQ, ST_TRACK: begin
          if (w_rise) begin
            w_state_next = ST_TRACK;
            w_push       = (r_state == ST_TRACK);
          end else if (w_cnt_inc == c_cnt_max) begin
            w_state_next = ST_TIMEOUT;
            w_to_timeout = 1'b1;
          end
        end
        ST_TIMEOUT: begin
          if (w_rise) begin
            w_state_next = ST_TRACK;
            w_recover    = 1'b1;
          end
        end
        default: w_state_next = ST_ACQ;
      endcase
    end
  end

  assign w_flush     = clear || w_to_timeout;
  assign w_cnt_inc   = r_cnt + 1'b1;
  assign w_full      = (r_fill == c_full);
  // Until the ring is full the slot being overwritten holds nothing to retire.
  assign w_old       = w_full ? r_buf[r_wr_ptr] : '0;
  assign w_sum_next  = r_sum + SUM_W'(w_cnt_inc) - SUM_W'(w_old);
  assign w_fill_next = w_full ? r_fill : r_fill + 1'b1;
  assign w_diff      = $signed({1'b0, w_cnt_inc}) - $signed({1'b0, period});
  assign w_abs       = w_diff[CNT_WIDTH] ? $unsigned(-w_diff) : $unsigned(w_diff);
  assign w_in_tol    = (w_abs <= c_tol);

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (data_valid) begin
      if (w_rise)                      r_cnt <= '0;
      else if (r_state != ST_TIMEOUT)  r_cnt <= w_cnt_inc;
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum    <= '0;
      r_fill   <= '0;
      r_wr_ptr <= '0;
      r_stab   <= '0;
      // NOTE: the ring is tiny and must read as zero after reset, so it is reset like any register.
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else if (w_flush) begin
      r_sum    <= '0;
      r_fill   <= '0;
      r_wr_ptr <= '0;
      r_stab   <= '0;
    end else if (w_push) begin
      r_buf[r_wr_ptr] <= w_cnt_inc;
      r_wr_ptr        <= r_wr_ptr + 1'b1;
      r_sum           <= w_sum_next;
      r_fill          <= w_fill_next;
      if (w_full) begin
        if (!w_in_tol)                 r_stab <= '0;
        else if (r_stab != c_stab_max) r_stab <= r_stab + 1'b1;
      end
    end
  end

  always_ff @(posedge adc_clk or negedge rst_n) begin
    if (!rst_n) begin
      period       <= '0;
      period_valid <= 1'b0;
      no_signal    <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (clear)             no_signal <= 1'b0;
      else if (w_to_timeout) no_signal <= 1'b1;
      else if (w_recover)    no_signal <= 1'b0;
      if (w_push && (w_fill_next == c_full)) begin
        period       <= CNT_WIDTH'(w_sum_next >> AVG_LOG2);
        period_valid <= 1'b1;
      end
    end
  end

  assign stable = (r_stab == c_stab_max);

endmodule
